audio_tone_gen: RTL



---
 rtl/audio_tone_pkg.sv | 22 ++
 rtl/audio_wave_shaper.sv | 38 +++
 rtl/audio_tone_gen.sv | 96 +++++++++
 3 files changed

// File: rtl/audio_tone_pkg.sv
// Shared constants for the multi-channel test-tone generator: waveform codes,
// default widths and the dither LFSR definition.
package audio_tone_pkg;

    localparam int DEFAULT_AUDIO_WIDTH = 16;
    localparam int DEFAULT_CHANNELS    = 2;
    localparam int DEFAULT_PHASE_WIDTH = 24;

    localparam logic [1:0] MODE_SAW      = 2'd0;
    localparam logic [1:0] MODE_SQUARE   = 2'd1;
    localparam logic [1:0] MODE_TRIANGLE = 2'd2;
    localparam logic [1:0] MODE_SILENCE  = 2'd3;

    // Right-shifting Galois form; mask bits correspond to taps 16,14,13,11.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] value);
        lfsr_next = {1'b0, value[15:1]} ^ (value[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/audio_wave_shaper.sv
// Combinational waveform shaper: maps the top slice of a phase accumulator to a
// two's complement sample for the selected mode, then applies attenuation.
module audio_wave_shaper
    import audio_tone_pkg::*;
#(
    parameter int AUDIO_WIDTH = DEFAULT_AUDIO_WIDTH
)
(
    input  logic [AUDIO_WIDTH-1:0] i_phase,
    input  logic [1:0]             i_mode,
    input  logic [3:0]             i_atten,
    output logic [AUDIO_WIDTH-1:0] o_sample
);

    localparam logic [AUDIO_WIDTH-1:0] POS_MAX = {1'b0, {(AUDIO_WIDTH-1){1'b1}}};
    localparam logic [AUDIO_WIDTH-1:0] NEG_MAX = {1'b1, {(AUDIO_WIDTH-2){1'b0}}, 1'b1};

    logic [AUDIO_WIDTH-1:0] w_tri;
    logic [AUDIO_WIDTH-1:0] w_raw;

    // Triangle folds the doubled phase on the second half-period.
    always_comb begin
        w_tri = {i_phase[AUDIO_WIDTH-2:0], 1'b0};
        if (i_phase[AUDIO_WIDTH-1]) begin
            w_tri = ~w_tri;
        end
        case (i_mode)
            MODE_SAW:      w_raw = {~i_phase[AUDIO_WIDTH-1], i_phase[AUDIO_WIDTH-2:0]};
            MODE_SQUARE:   w_raw = i_phase[AUDIO_WIDTH-1] ? NEG_MAX : POS_MAX;
            MODE_TRIANGLE: w_raw = {~w_tri[AUDIO_WIDTH-1], w_tri[AUDIO_WIDTH-2:0]};
            MODE_SILENCE:  w_raw = '0;
            default:       w_raw = '0;
        endcase
    end

    assign o_sample = $signed(w_raw) >>> i_atten;

endmodule

// File: rtl/audio_tone_gen.sv
// Multi-channel test-tone source feeding the live-audio FIFO write side.
// Define AUDIO_TONE_GEN_DITHER_EN to add LFSR dither to every sample.
module audio_tone_gen
    import audio_tone_pkg::*;
#(
    parameter int AUDIO_WIDTH = DEFAULT_AUDIO_WIDTH,
    parameter int CHANNELS    = DEFAULT_CHANNELS,
    parameter int PHASE_WIDTH = DEFAULT_PHASE_WIDTH
)
(
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            i_run,
    input  logic [1:0]                      i_mode,
    input  logic [3:0]                      i_atten,
    input  logic [CHANNELS*PHASE_WIDTH-1:0] i_phase_inc,
    output logic [AUDIO_WIDTH*CHANNELS-1:0] o_data_out,
    output logic                            o_en_out,
    input  logic                            i_full_in
);

    localparam int FRAME_WIDTH = AUDIO_WIDTH * CHANNELS;

    logic [PHASE_WIDTH-1:0] r_phase  [CHANNELS];
    logic [AUDIO_WIDTH-1:0] w_shaped [CHANNELS];
    logic [AUDIO_WIDTH-1:0] w_sample [CHANNELS];
    logic [FRAME_WIDTH-1:0] r_frame;
    logic [FRAME_WIDTH-1:0] w_nextFrame;
    logic                   r_valid;
    logic                   w_transfer;
    logic                   w_load;

    // A frame is reloaded when the slot is empty and running, or when the
    // current frame is consumed, so back-to-back transfers need no bubble.
    assign w_transfer = r_valid & i_run & ~i_full_in;
    assign w_load     = (~r_valid & i_run) | w_transfer;
    assign o_en_out   = w_transfer;
    assign o_data_out = r_frame;

`ifdef AUDIO_TONE_GEN_DITHER_EN
    localparam logic [AUDIO_WIDTH-1:0] POS_MAX = {1'b0, {(AUDIO_WIDTH-1){1'b1}}};

    logic [15:0] r_lfsr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lfsr <= LFSR_SEED;
        end else if (w_load) begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end
`endif

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        audio_wave_shaper #(
            .AUDIO_WIDTH (AUDIO_WIDTH)
        ) u_shaper (
            .i_phase  (r_phase[c][PHASE_WIDTH-1 -: AUDIO_WIDTH]),
            .i_mode   (i_mode),
            .i_atten  (i_atten),
            .o_sample (w_shaped[c])
        );
`ifdef AUDIO_TONE_GEN_DITHER_EN
        // Dither saturates at positive full scale instead of wrapping negative.
        assign w_sample[c] = (r_lfsr[0] && (w_shaped[c] != POS_MAX)) ?
                             w_shaped[c] + 1'b1 : w_shaped[c];
`else
        assign w_sample[c] = w_shaped[c];
`endif
    end

    // Channel 0 lands in the most significant slice, matching {left,right}.
    always_comb begin
        w_nextFrame = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_nextFrame[(CHANNELS-1-c)*AUDIO_WIDTH +: AUDIO_WIDTH] = w_sample[c];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_phase[c] <= '0;
            end
            r_frame <= '0;
            r_valid <= 1'b0;
        end else if (w_load) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_phase[c] <= r_phase[c] + i_phase_inc[c*PHASE_WIDTH +: PHASE_WIDTH];
            end
            r_frame <= w_nextFrame;
            r_valid <= 1'b1;
        end
    end

endmodule
